// File: rtl/munoc_write_request_packetizer_pkg.sv
// Shared flit layout for the write-request packetizer and its slave-side depacketizer.
// Header and data words are MSB-first and left-aligned in the serializer load word.
package munoc_write_request_packetizer_pkg;

    localparam int BW_FLIT    = 8;
    localparam int BW_ADDR    = 32;
    localparam int BW_DATA    = 32;
    localparam int BW_TID     = 4;
    localparam int BW_NODE_ID = 4;
    localparam int NB         = BW_DATA / 8;

    localparam int HW = 2 * BW_NODE_ID + BW_TID + BW_ADDR + 13;
    localparam int DW = 1 + 9 * NB;
    localparam int HF = (HW + BW_FLIT - 1) / BW_FLIT;
    localparam int DF = (DW + BW_FLIT - 1) / BW_FLIT;

    localparam int SR_CHUNKS = (HF > DF) ? HF : DF;
    localparam int SR_W      = SR_CHUNKS * BW_FLIT;
    localparam int CNT_W     = (SR_CHUNKS > 1) ? $clog2(SR_CHUNKS) : 1;

    localparam logic [CNT_W-1:0] HF_LAST = CNT_W'(HF - 1);
    localparam logic [CNT_W-1:0] DF_LAST = CNT_W'(DF - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HEAD,
        ST_DATA
    } state_t;

    typedef struct packed {
        logic [BW_NODE_ID-1:0] slave_node;
        logic [BW_NODE_ID-1:0] master_node;
        logic [BW_TID-1:0]     id;
        logic [BW_ADDR-1:0]    addr;
        logic [7:0]            len;
        logic [2:0]            size;
        logic [1:0]            burst;
    } hdr_t;

    function automatic logic [SR_W-1:0] pack_hdr(input hdr_t h);
        return {h, {(SR_W - HW){1'b0}}};
    endfunction

    // Byte 0 sits just below wlast, so it leaves the link first.
    function automatic logic [SR_W-1:0] pack_data(input logic [BW_DATA-1:0] data,
                                                  input logic [NB-1:0]      strb,
                                                  input logic               last);
        logic [DW-1:0] dw;
        dw[DW-1] = last;
        for (int i = 0; i < NB; i++) begin
            dw[DW-2-9*i -: 9] = {strb[i], data[8*i +: 8]};
        end
        return {dw, {(SR_W - DW){1'b0}}};
    endfunction

endpackage

// File: rtl/munoc_write_request_packetizer_if.sv
// AXI write-request channels plus the forward flit link of the packetizer.
// slave is the packetizer side; master is the AXI master / router side.
interface munoc_write_request_packetizer_if;
    import munoc_write_request_packetizer_pkg::*;

    logic [BW_NODE_ID-1:0] aw_slave_node;
    logic [BW_NODE_ID-1:0] aw_master_node;
    logic [BW_TID-1:0]     awid;
    logic [BW_ADDR-1:0]    awaddr;
    logic [7:0]            awlen;
    logic [2:0]            awsize;
    logic [1:0]            awburst;
    logic                  awvalid;
    logic                  awready;
    logic [BW_DATA-1:0]    wdata;
    logic [NB-1:0]         wstrb;
    logic                  wlast;
    logic                  wvalid;
    logic                  wready;
    logic                  link_valid;
    logic                  link_head;
    logic                  link_tail;
    logic [BW_FLIT-1:0]    link_flit;
    logic                  link_ready;
    logic                  len_error;

    modport slave (
        input  aw_slave_node, aw_master_node, awid, awaddr, awlen, awsize, awburst, awvalid,
        input  wdata, wstrb, wlast, wvalid, link_ready,
        output awready, wready, link_valid, link_head, link_tail, link_flit, len_error
    );

    modport master (
        output aw_slave_node, aw_master_node, awid, awaddr, awlen, awsize, awburst, awvalid,
        output wdata, wstrb, wlast, wvalid, link_ready,
        input  awready, wready, link_valid, link_head, link_tail, link_flit, len_error
    );

endinterface

// File: rtl/munoc_flit_serializer.sv
// Parallel-load shift register emitting BW_FLIT chunks MSB first with head/tail tags.
// Latency: first chunk valid the cycle after load; one chunk per accepted link cycle.
// Backpressure: link_ready low holds flit/head/tail; load only when empty or last chunk leaving.
module munoc_flit_serializer
    import munoc_write_request_packetizer_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [SR_W-1:0]    load_dat,
    input  logic [CNT_W-1:0]   load_last_idx,
    input  logic               load_head,
    input  logic               load_tail,
    input  logic               link_ready,
    output logic               link_valid,
    output logic               link_head,
    output logic               link_tail,
    output logic [BW_FLIT-1:0] link_flit,
    output logic               last_chunk
);

    logic [SR_W-1:0]  sreg;
    logic [CNT_W-1:0] cnt;
    logic             tail_pend;
    logic             fire;

    assign fire       = link_valid && link_ready;
    assign last_chunk = (cnt == '0);
    assign link_flit  = sreg[SR_W-1 -: BW_FLIT];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sreg       <= '0;
            cnt        <= '0;
            tail_pend  <= 1'b0;
            link_valid <= 1'b0;
            link_head  <= 1'b0;
            link_tail  <= 1'b0;
        end else if (load) begin
            sreg       <= load_dat;
            cnt        <= load_last_idx;
            tail_pend  <= load_tail;
            link_valid <= 1'b1;
            link_head  <= load_head;
            link_tail  <= load_tail && (load_last_idx == '0);
        end else if (fire) begin
            if (cnt == '0) begin
                link_valid <= 1'b0;
                link_head  <= 1'b0;
                link_tail  <= 1'b0;
            end else begin
                sreg      <= sreg << BW_FLIT;
                cnt       <= cnt - 1'b1;
                link_head <= 1'b0;
                // Tail rides only on the final chunk of the final beat.
                link_tail <= tail_pend && (cnt == CNT_W'(1));
            end
        end
    end

endmodule

// File: rtl/munoc_write_request_packetizer.sv
// Packs one AW header plus awlen+1 W beats into a single head..tail flit packet.
// Latency: first header flit valid one cycle after the AW handshake.
// Backpressure: link_ready low stalls the link; W is taken back-to-back when the last chunk leaves.
module munoc_write_request_packetizer
    import munoc_write_request_packetizer_pkg::*;
(
    input  logic                             clk,
    input  logic                             rst,
    munoc_write_request_packetizer_if.slave  bus
);

    state_t           state;
    logic             awready_q;
    logic [7:0]       beat_cnt;
    logic             last_in;
    logic             len_error_q;

    hdr_t             aw_hdr;
    logic             aw_hs;
    logic             w_hs;
    logic             fire;
    logic             ser_load;
    logic [SR_W-1:0]  ser_dat;
    logic [CNT_W-1:0] ser_last_idx;
    logic             ser_last;
    logic             link_valid;
    logic             link_head;
    logic             link_tail;
    logic [BW_FLIT-1:0] link_flit;

    assign aw_hdr = {bus.aw_slave_node, bus.aw_master_node, bus.awid, bus.awaddr,
                     bus.awlen, bus.awsize, bus.awburst};

    assign bus.awready = awready_q;
    assign bus.wready  = (state == ST_DATA) && !last_in &&
                         (!link_valid || (ser_last && bus.link_ready));

    assign aw_hs = (state == ST_IDLE) && bus.awvalid && awready_q;
    assign w_hs  = bus.wvalid && bus.wready;
    assign fire  = link_valid && bus.link_ready;

    assign ser_load     = aw_hs || w_hs;
    assign ser_dat      = (state == ST_IDLE) ? pack_hdr(aw_hdr)
                                             : pack_data(bus.wdata, bus.wstrb, bus.wlast);
    assign ser_last_idx = (state == ST_IDLE) ? HF_LAST : DF_LAST;

    munoc_flit_serializer u_ser (
        .clk           (clk),
        .rst           (rst),
        .load          (ser_load),
        .load_dat      (ser_dat),
        .load_last_idx (ser_last_idx),
        .load_head     (state == ST_IDLE),
        .load_tail     ((state == ST_DATA) && (beat_cnt == 8'd0)),
        .link_ready    (bus.link_ready),
        .link_valid    (link_valid),
        .link_head     (link_head),
        .link_tail     (link_tail),
        .link_flit     (link_flit),
        .last_chunk    (ser_last)
    );

    assign bus.link_valid = link_valid;
    assign bus.link_head  = link_head;
    assign bus.link_tail  = link_tail;
    assign bus.link_flit  = link_flit;
    assign bus.len_error  = len_error_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            awready_q   <= 1'b0;
            beat_cnt    <= 8'd0;
            last_in     <= 1'b0;
            len_error_q <= 1'b0;
        end else begin
            // Packet length follows awlen; wlast is only cross-checked.
            len_error_q <= w_hs && (bus.wlast != (beat_cnt == 8'd0));
            case (state)
                ST_IDLE: begin
                    if (aw_hs) begin
                        state     <= ST_HEAD;
                        awready_q <= 1'b0;
                        beat_cnt  <= bus.awlen;
                        last_in   <= 1'b0;
                    end else begin
                        awready_q <= 1'b1;
                    end
                end
                ST_HEAD: begin
                    if (fire && ser_last) state <= ST_DATA;
                end
                ST_DATA: begin
                    if (w_hs) begin
                        if (beat_cnt == 8'd0) last_in <= 1'b1;
                        else                  beat_cnt <= beat_cnt - 8'd1;
                    end
                    if (fire && link_tail) begin
                        state     <= ST_IDLE;
                        awready_q <= 1'b1;
                        last_in   <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_munoc_write_request_packetizer.sv
// Directed bench: table of write packets checked flit-by-flit against a bit-level model,
// plus hand-written reset-mid-packet and back-to-back AW sequences.
module tb_munoc_write_request_packetizer;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    munoc_write_request_packetizer_if bus();

    munoc_write_request_packetizer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [3:0]  slv;
        logic [3:0]  mst;
        logic [3:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic [31:0] seed;
        int          bad;        // beat whose wlast is inverted, -1 for none
        bit          rnd;        // 50% random link_ready
        int          exp_err;
        int          exp_flits;
    } vec_t;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int len_err_cnt;
    bit rnd_ready = 0;
    bit prev_stall = 0;
    logic [10:0] prev_rec;

    logic [56:0] aw_q[$];
    logic [36:0] w_q[$];
    logic [9:0]  exp_q[$];
    logic [9:0]  got_q[$];
    int          got_cyc[$];
    int          aw_cyc[$];
    int          tail_cyc[$];

    vec_t vecs[6];
    logic [7:0] exp0[13];

    function automatic void check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    function automatic logic [31:0] bdata(input vec_t v, input int b);
        return v.seed + 32'(b) * 32'h0101_0101;
    endfunction

    function automatic logic [3:0] bstrb(input int b);
        return 4'hF ^ 4'(b);
    endfunction

    function automatic logic bwlast(input vec_t v, input int b);
        return (b == int'(v.len)) ^ (b == v.bad);
    endfunction

    // Appends the expected flits of one packet and queues its AW and W beats.
    task automatic add_pkt(input vec_t v);
        bit bq[$];
        logic [56:0] hw;
        logic [31:0] d;
        logic [3:0]  s;
        logic        wl;
        logic [7:0]  byt;
        int nf;
        hw = {v.slv, v.mst, v.id, v.addr, v.len, v.size, v.burst};
        for (int i = 56; i >= 0; i--) bq.push_back(hw[i]);
        while (bq.size() % 8 != 0) bq.push_back(1'b0);
        aw_q.push_back(hw);
        for (int b = 0; b <= int'(v.len); b++) begin
            d  = bdata(v, b);
            s  = bstrb(b);
            wl = bwlast(v, b);
            bq.push_back(wl);
            for (int i = 0; i < 4; i++) begin
                bq.push_back(s[i]);
                for (int j = 7; j >= 0; j--) bq.push_back(d[8*i+j]);
            end
            while (bq.size() % 8 != 0) bq.push_back(1'b0);
            w_q.push_back({wl, s, d});
        end
        nf = bq.size() / 8;
        for (int f = 0; f < nf; f++) begin
            for (int k = 0; k < 8; k++) byt[7-k] = bq[8*f+k];
            exp_q.push_back({(f == 0), (f == nf - 1), byt});
        end
    endtask

    task automatic step();
        @(negedge clk);
        bus.link_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        bus.awvalid = (aw_q.size() != 0);
        if (aw_q.size() != 0)
            {bus.aw_slave_node, bus.aw_master_node, bus.awid, bus.awaddr,
             bus.awlen, bus.awsize, bus.awburst} = aw_q[0];
        bus.wvalid = (w_q.size() != 0);
        if (w_q.size() != 0) {bus.wlast, bus.wstrb, bus.wdata} = w_q[0];
        #1;
        if (prev_stall)
            check("stall_hold", {53'd0, bus.link_valid, bus.link_head, bus.link_tail, bus.link_flit},
                  {53'd0, prev_rec});
        prev_stall = bus.link_valid && !bus.link_ready;
        prev_rec   = {1'b1, bus.link_head, bus.link_tail, bus.link_flit};
        if (bus.link_valid && bus.link_ready) begin
            got_q.push_back({bus.link_head, bus.link_tail, bus.link_flit});
            got_cyc.push_back(cyc);
            if (bus.link_tail) tail_cyc.push_back(cyc);
        end
        if (bus.len_error) len_err_cnt++;
        if (bus.awvalid && bus.awready) begin
            void'(aw_q.pop_front());
            aw_cyc.push_back(cyc);
        end
        if (bus.wvalid && bus.wready) void'(w_q.pop_front());
        cyc++;
    endtask

    task automatic clear_run();
        exp_q.delete(); got_q.delete(); got_cyc.delete();
        aw_cyc.delete(); tail_cyc.delete();
        len_err_cnt = 0;
    endtask

    task automatic wait_done(input int n);
        for (int k = 0; k < 2000; k++) begin
            if (got_q.size() >= n && aw_q.size() == 0 && w_q.size() == 0) break;
            step();
        end
        repeat (4) step();
    endtask

    task automatic compare_stream(input string nm);
        check({nm, "_nflits"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            check($sformatf("%s_flit%0d", nm, i + 1), 64'(got_q[i]), 64'(exp_q[i]));
    endtask

    task automatic check_hand_bytes(input string nm);
        for (int i = 0; i < 13 && i < got_q.size(); i++)
            check($sformatf("%s_byte%0d", nm, i + 1), 64'(got_q[i][7:0]), 64'(exp0[i]));
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        string nm;
        nm = $sformatf("vec%0d", idx);
        clear_run();
        add_pkt(v);
        rnd_ready = v.rnd;
        wait_done(v.exp_flits);
        rnd_ready = 0;
        check({nm, "_count"}, 64'(got_q.size()), 64'(v.exp_flits));
        compare_stream(nm);
        check({nm, "_len_error"}, 64'(len_err_cnt), 64'(v.exp_err));
        if (!v.rnd && got_q.size() == v.exp_flits)
            check({nm, "_data_span"}, 64'(got_cyc[v.exp_flits-1] - got_cyc[8]),
                  64'(v.exp_flits - 9));
    endtask

    initial begin
        vecs[0] = '{4'h2, 4'h5, 4'h3, 32'h1000_0040, 8'd0, 3'd2, 2'd1, 32'hA1B2_C3D4, -1, 1'b0, 0, 13};
        vecs[1] = '{4'h7, 4'h1, 4'hA, 32'h2000_0100, 8'd3, 3'd2, 2'd1, 32'h1122_3344, -1, 1'b0, 0, 28};
        vecs[2] = '{4'hF, 4'h0, 4'h5, 32'hFFFF_FFFC, 8'd7, 3'd2, 2'd2, 32'hDEAD_BEEF, -1, 1'b1, 0, 48};
        vecs[3] = '{4'h3, 4'h9, 4'h1, 32'h0000_0010, 8'd1, 3'd1, 2'd1, 32'h5566_7788,  0, 1'b0, 1, 18};
        vecs[4] = '{4'h1, 4'hE, 4'hC, 32'h8000_0000, 8'd0, 3'd0, 2'd0, 32'h0F0F_0F0F,  0, 1'b0, 1, 13};
        vecs[5] = '{4'hA, 4'h6, 4'h7, 32'h1234_5678, 8'd2, 3'd2, 2'd1, 32'hCAFE_F00D,  2, 1'b1, 1, 23};
        exp0 = '{8'h25, 8'h31, 8'h00, 8'h00, 8'h04, 8'h00, 8'h04, 8'h80,
                 8'hF5, 8'h38, 8'h7B, 8'h2D, 8'h08};

        rst = 1'b1;
        bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.link_ready = 1'b0;
        bus.aw_slave_node = '0; bus.aw_master_node = '0; bus.awid = '0; bus.awaddr = '0;
        bus.awlen = '0; bus.awsize = '0; bus.awburst = '0;
        bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_awready",    64'(bus.awready),    64'd0);
        check("rst_wready",     64'(bus.wready),     64'd0);
        check("rst_link_valid", 64'(bus.link_valid), 64'd0);
        check("rst_link_head",  64'(bus.link_head),  64'd0);
        check("rst_link_tail",  64'(bus.link_tail),  64'd0);
        check("rst_link_flit",  64'(bus.link_flit),  64'd0);
        check("rst_len_error",  64'(bus.len_error),  64'd0);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i], i);
            if (i == 0) check_hand_bytes("vec0_hand");
        end

        // Reset in the middle of a header, then a clean packet.
        clear_run();
        aw_q.push_back({vecs[0].slv, vecs[0].mst, vecs[0].id, vecs[0].addr,
                        vecs[0].len, vecs[0].size, vecs[0].burst});
        for (int k = 0; k < 100 && got_q.size() < 4; k++) step();
        @(posedge clk);
        #1;
        check("pre_rst_link_valid", 64'(bus.link_valid), 64'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_link_valid", 64'(bus.link_valid), 64'd0);
        check("mid_rst_awready",    64'(bus.awready),    64'd0);
        aw_q.delete(); w_q.delete(); prev_stall = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        run_vec(vecs[0], 10);
        check_hand_bytes("post_rst");

        // Two AWs back to back: second awready exactly one cycle after first tail.
        clear_run();
        add_pkt(vecs[0]);
        add_pkt(vecs[4]);
        wait_done(26);
        compare_stream("b2b");
        check("b2b_aw_count", 64'(aw_cyc.size()), 64'd2);
        check("b2b_tail_count", 64'(tail_cyc.size()), 64'd2);
        if (aw_cyc.size() == 2 && tail_cyc.size() >= 1)
            check("b2b_awready_gap", 64'(aw_cyc[1] - tail_cyc[0]), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
